// File: rtl/uart_frame_codec.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_codec
//  Description : UART string framer/deframer. RX parses DELIM*N, payload,
//                DELIM*N frames from a byte stream into a flat payload vector;
//                TX wraps a flat payload vector in the same framing and feeds
//                a byte-wide UART transmitter through a req/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_codec #(
    parameter int         DATA_MAX    = 137,
    parameter logic [7:0] DELIM       = 8'h26,
    parameter int         DELIM_CNT   = 2,
    parameter int         TIMEOUT_CLK = 49_999,
    parameter int         LEN_W       = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_byte_vld,
    output logic [DATA_MAX*8-1:0]   rx_string,
    output logic [LEN_W-1:0]        rx_length,
    output logic                    rx_busy,
    output logic                    rx_done,
    output logic                    rx_err,
    input  logic [DATA_MAX*8-1:0]   tx_string,
    input  logic [LEN_W-1:0]        tx_length,
    input  logic                    tx_req,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic [7:0]              tx_byte,
    output logic                    tx_byte_req,
    input  logic                    tx_byte_done
);

    localparam int CNT_W = $clog2(DELIM_CNT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLK + 1);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DELIM_CNT - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DELIM_CNT);
    localparam logic [LEN_W-1:0] c_len_max  = LEN_W'(DATA_MAX);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT_CLK - 1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_HEAD = 2'd1,
        R_DATA = 2'd2,
        R_TAIL = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_HEAD = 2'd1,
        T_DATA = 2'd2,
        T_TAIL = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------------
    rx_state_t              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;        // head or tail delimiter count
    logic [LEN_W-1:0]       rx_wr_idx_q, rx_wr_idx_d;
    logic [TO_W-1:0]        rx_idle_q, rx_idle_d;
    logic [7:0]             rx_buf_q [DATA_MAX];
    logic [7:0]             rx_buf_d [DATA_MAX];
    logic [DATA_MAX*8-1:0]  rx_string_q, rx_string_d;
    logic [LEN_W-1:0]       rx_length_q, rx_length_d;
    logic                   rx_done_q, rx_done_d;
    logic                   rx_err_q, rx_err_d;
    logic                   rx_complete;
    logic                   rx_is_delim;

    assign rx_is_delim = (rx_byte == DELIM);

    // RX next-state: frame parsing, overflow/bad-tail/timeout drop, publish on completion
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_wr_idx_d = rx_wr_idx_q;
        rx_idle_d   = rx_idle_q;
        rx_buf_d    = rx_buf_q;
        rx_string_d = rx_string_q;
        rx_length_d = rx_length_q;
        rx_done_d   = 1'b0;
        rx_err_d    = 1'b0;
        rx_complete = 1'b0;

        if (rx_byte_vld) begin
            rx_idle_d = '0;
            unique case (rx_state_q)
                R_IDLE: begin
                    if (rx_is_delim) begin
                        rx_wr_idx_d = '0;
                        rx_cnt_d    = c_cnt_one;
                        rx_state_d  = (DELIM_CNT == 1) ? R_DATA : R_HEAD;
                    end
                end
                R_HEAD: begin
                    if (!rx_is_delim) begin
                        rx_state_d = R_IDLE;                 // line noise, drop quietly
                    end else if (rx_cnt_q == c_cnt_last) begin
                        rx_state_d = R_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_is_delim) begin
                        if (DELIM_CNT == 1) begin
                            rx_complete = 1'b1;
                        end else begin
                            rx_cnt_d   = c_cnt_one;
                            rx_state_d = R_TAIL;
                        end
                    end else if (rx_wr_idx_q == c_len_max) begin
                        rx_err_d   = 1'b1;
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_buf_d[rx_wr_idx_q] = rx_byte;
                        rx_wr_idx_d           = rx_wr_idx_q + 1'b1;
                    end
                end
                R_TAIL: begin
                    if (!rx_is_delim) begin
                        rx_err_d   = 1'b1;
                        rx_state_d = R_IDLE;
                    end else if (rx_cnt_q == c_cnt_last) begin
                        rx_complete = 1'b1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_d = R_IDLE;
            endcase
        end else if (rx_state_q != R_IDLE) begin
            if (rx_idle_q == c_to_last) begin
                rx_err_d   = 1'b1;
                rx_state_d = R_IDLE;
                rx_idle_d  = '0;
            end else begin
                rx_idle_d = rx_idle_q + 1'b1;
            end
        end

        // The buffer is never cleared between frames, so stale bytes past
        // the new length are masked off when the payload is published.
        if (rx_complete) begin
            rx_done_d   = 1'b1;
            rx_state_d  = R_IDLE;
            rx_length_d = rx_wr_idx_q;
            for (int i = 0; i < DATA_MAX; i++) begin
                rx_string_d[8*i +: 8] = (LEN_W'(i) < rx_wr_idx_q) ? rx_buf_q[i] : 8'h00;
            end
        end
    end

    // RX state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_q  <= R_IDLE;
            rx_cnt_q    <= '0;
            rx_wr_idx_q <= '0;
            rx_idle_q   <= '0;
            for (int i = 0; i < DATA_MAX; i++) begin
                rx_buf_q[i] <= 8'h00;
            end
            rx_string_q <= '0;
            rx_length_q <= '0;
            rx_done_q   <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_wr_idx_q <= rx_wr_idx_d;
            rx_idle_q   <= rx_idle_d;
            rx_buf_q    <= rx_buf_d;
            rx_string_q <= rx_string_d;
            rx_length_q <= rx_length_d;
            rx_done_q   <= rx_done_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign rx_string = rx_string_q;
    assign rx_length = rx_length_q;
    assign rx_busy   = (rx_state_q != R_IDLE);
    assign rx_done   = rx_done_q;
    assign rx_err    = rx_err_q;

    // ------------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------------
    tx_state_t              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;        // delimiters issued in this head/tail
    logic [LEN_W-1:0]       tx_idx_q, tx_idx_d;        // next payload byte to issue
    logic [LEN_W-1:0]       tx_len_q, tx_len_d;
    logic [7:0]             tx_buf_q [DATA_MAX];
    logic [7:0]             tx_buf_d [DATA_MAX];
    logic                   tx_wait_q, tx_wait_d;      // a byte is with uart_tx, awaiting done
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   tx_byte_req_q, tx_byte_req_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_send;
    logic [7:0]             tx_send_byte;

    // TX next-state: accept a request, then issue one byte per uart_tx done
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_idx_d      = tx_idx_q;
        tx_len_d      = tx_len_q;
        tx_buf_d      = tx_buf_q;
        tx_wait_d     = tx_wait_q;
        tx_byte_d     = tx_byte_q;
        tx_byte_req_d = 1'b0;
        tx_done_d     = 1'b0;
        tx_send       = 1'b0;
        tx_send_byte  = DELIM;

        if (tx_state_q == T_IDLE) begin
            if (tx_req) begin
                for (int i = 0; i < DATA_MAX; i++) begin
                    tx_buf_d[i] = tx_string[8*i +: 8];
                end
                tx_len_d   = (tx_length > c_len_max) ? c_len_max : tx_length;
                tx_idx_d   = '0;
                tx_cnt_d   = c_cnt_one;
                tx_state_d = T_HEAD;
                tx_send    = 1'b1;
            end
        end else if (tx_wait_q && tx_byte_done) begin
            tx_wait_d = 1'b0;
            case (tx_state_q)
                T_HEAD: begin
                    if (tx_cnt_q != c_cnt_full) begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                        tx_send  = 1'b1;
                    end else if (tx_len_q != '0) begin
                        tx_state_d   = T_DATA;
                        tx_send_byte = tx_buf_q[0];
                        tx_idx_d     = LEN_W'(1);
                        tx_send      = 1'b1;
                    end else begin
                        tx_state_d = T_TAIL;
                        tx_cnt_d   = c_cnt_one;
                        tx_send    = 1'b1;
                    end
                end
                T_DATA: begin
                    if (tx_idx_q != tx_len_q) begin
                        tx_send_byte = tx_buf_q[tx_idx_q];
                        tx_idx_d     = tx_idx_q + 1'b1;
                        tx_send      = 1'b1;
                    end else begin
                        tx_state_d = T_TAIL;
                        tx_cnt_d   = c_cnt_one;
                        tx_send    = 1'b1;
                    end
                end
                T_TAIL: begin
                    if (tx_cnt_q != c_cnt_full) begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                        tx_send  = 1'b1;
                    end else begin
                        tx_done_d  = 1'b1;
                        tx_state_d = T_IDLE;
                    end
                end
                default: tx_state_d = T_IDLE;
            endcase
        end

        if (tx_send) begin
            tx_byte_req_d = 1'b1;
            tx_byte_d     = tx_send_byte;
            tx_wait_d     = 1'b1;
        end
    end

    // TX state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q    <= T_IDLE;
            tx_cnt_q      <= '0;
            tx_idx_q      <= '0;
            tx_len_q      <= '0;
            for (int i = 0; i < DATA_MAX; i++) begin
                tx_buf_q[i] <= 8'h00;
            end
            tx_wait_q     <= 1'b0;
            tx_byte_q     <= 8'h00;
            tx_byte_req_q <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_idx_q      <= tx_idx_d;
            tx_len_q      <= tx_len_d;
            tx_buf_q      <= tx_buf_d;
            tx_wait_q     <= tx_wait_d;
            tx_byte_q     <= tx_byte_d;
            tx_byte_req_q <= tx_byte_req_d;
            tx_done_q     <= tx_done_d;
        end
    end

    assign tx_busy     = (tx_state_q != T_IDLE);
    assign tx_done     = tx_done_q;
    assign tx_byte     = tx_byte_q;
    assign tx_byte_req = tx_byte_req_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_codec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_codec
//  Description : Scoreboard bench for uart_frame_codec. Frames are built from
//                random payloads; the expected RX events and TX byte stream
//                are derived from the framing rules and checked by monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_frame_codec;

    localparam int         DATA_MAX    = 137;
    localparam logic [7:0] DELIM       = 8'h26;
    localparam int         DELIM_CNT   = 2;
    localparam int         TIMEOUT_CLK = 49_999;
    localparam int         LEN_W       = 8;
    localparam int         SW          = DATA_MAX * 8;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        bit            is_err;
        int            len;
        logic [SW-1:0] str;
        int            due;
        int            tol;
    } rx_exp_t;

    logic                sys_clk      = 1'b0;
    logic                sys_rst_n    = 1'b1;
    logic [7:0]          rx_byte      = 8'h00;
    logic                rx_byte_vld  = 1'b0;
    logic [SW-1:0]       rx_string;
    logic [LEN_W-1:0]    rx_length;
    logic                rx_busy;
    logic                rx_done;
    logic                rx_err;
    logic [SW-1:0]       tx_string    = '0;
    logic [LEN_W-1:0]    tx_length    = '0;
    logic                tx_req       = 1'b0;
    logic                tx_busy;
    logic                tx_done;
    logic [7:0]          tx_byte;
    logic                tx_byte_req;
    logic                tx_byte_done = 1'b0;

    int      cyc = 0;
    int      n_checks = 0;
    int      n_errors = 0;

    rx_exp_t       rx_q [$];
    rx_exp_t       rx_e;
    logic [SW-1:0] last_good     = '0;
    int            last_good_len = 0;
    int            rx_last_cyc   = 0;
    int            rx_fd;
    logic [7:0]    rx_ab, rx_eb;

    logic [7:0]    tx_q [$];
    logic [7:0]    tx_eb;
    int            tx_done_pend   = 0;
    int            tx_req_due     = 0;
    int            tx_done_cyc    = 0;
    int            tx_delay       = 4;
    bit            tx_outstanding = 1'b0;

    uart_frame_codec #(
        .DATA_MAX    (DATA_MAX),
        .DELIM       (DELIM),
        .DELIM_CNT   (DELIM_CNT),
        .TIMEOUT_CLK (TIMEOUT_CLK),
        .LEN_W       (LEN_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_byte      (rx_byte),
        .rx_byte_vld  (rx_byte_vld),
        .rx_string    (rx_string),
        .rx_length    (rx_length),
        .rx_busy      (rx_busy),
        .rx_done      (rx_done),
        .rx_err       (rx_err),
        .tx_string    (tx_string),
        .tx_length    (tx_length),
        .tx_req       (tx_req),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_byte      (tx_byte),
        .tx_byte_req  (tx_byte_req),
        .tx_byte_done (tx_byte_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bq_t rand_payload(input int n);
        bq_t        p;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == DELIM) b = b ^ 8'h01;
            p.push_back(b);
        end
        return p;
    endfunction

    function automatic logic [SW-1:0] pack(input bq_t p);
        logic [SW-1:0] r = '0;
        for (int i = 0; i < p.size() && i < DATA_MAX; i++) r[8*i +: 8] = p[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- RX stimulus ----------------
    task automatic rx_send(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) tick();
        rx_byte     = b;
        rx_byte_vld = 1'b1;
        tick();
        rx_byte_vld = 1'b0;
        rx_last_cyc = cyc;
    endtask

    task automatic push_rx_err(input int due, input int tol);
        rx_exp_t e;
        e.is_err = 1'b1;
        e.len    = last_good_len;
        e.str    = last_good;
        e.due    = due;
        e.tol    = tol;
        rx_q.push_back(e);
    endtask

    task automatic rx_frame_good(input bq_t p);
        rx_exp_t e;
        repeat (DELIM_CNT) rx_send(DELIM);
        foreach (p[i]) rx_send(p[i]);
        repeat (DELIM_CNT) rx_send(DELIM);
        e.is_err      = 1'b0;
        e.len         = p.size();
        e.str         = pack(p);
        e.due         = rx_last_cyc;
        e.tol         = 0;
        last_good     = e.str;
        last_good_len = e.len;
        rx_q.push_back(e);
    endtask

    task automatic rx_frame_overflow();
        bq_t p;
        p = rand_payload(DATA_MAX + 1);
        repeat (DELIM_CNT) rx_send(DELIM);
        foreach (p[i]) rx_send(p[i]);
        push_rx_err(rx_last_cyc, 0);
    endtask

    task automatic rx_frame_badtail(input int n);
        bq_t p;
        p = rand_payload(n);
        repeat (DELIM_CNT) rx_send(DELIM);
        foreach (p[i]) rx_send(p[i]);
        rx_send(DELIM);
        rx_send(8'h5A);
        push_rx_err(rx_last_cyc, 0);
    endtask

    task automatic rx_noise();
        rx_send(DELIM);
        chk(rx_busy == 1'b1, "rx_busy_in_head", rx_busy, 1);
        rx_send(8'h78);
        chk(rx_busy == 1'b0, "rx_busy_after_noise", rx_busy, 0);
    endtask

    task automatic wait_rx_drain(input int bound);
        int k = 0;
        while (rx_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        chk(rx_q.size() == 0, "rx_event_arrived", 64'(rx_q.size()), 0);
        rx_q.delete();
    endtask

    // ---------------- TX stimulus ----------------
    task automatic tx_start(input bq_t p, input int len_field);
        int k = 0;
        int n;
        while (tx_busy && k < 10000) begin
            tick();
            k++;
        end
        chk(!tx_busy, "tx_idle_before_req", tx_busy, 0);
        tx_string = pack(p);
        tx_length = LEN_W'(len_field);
        tx_req    = 1'b1;
        tick();
        tx_req     = 1'b0;
        tx_req_due = cyc;
        n = (len_field > DATA_MAX) ? DATA_MAX : len_field;
        repeat (DELIM_CNT) tx_q.push_back(DELIM);
        for (int i = 0; i < n; i++) tx_q.push_back(p[i]);
        repeat (DELIM_CNT) tx_q.push_back(DELIM);
        tx_done_pend++;
    endtask

    task automatic tx_send(input bq_t p, input int len_field, input bit poke);
        int k = 0;
        tx_start(p, len_field);
        if (poke) begin
            repeat (3) tick();
            tx_string = ~tx_string;
            tx_length = LEN_W'(5);
            tx_req    = 1'b1;
            tick();
            tx_req    = 1'b0;
        end
        while (tx_done_pend != 0 && k < (DATA_MAX + 8) * (tx_delay + 3)) begin
            tick();
            k++;
        end
        chk(tx_done_pend == 0, "tx_frame_finished", 64'(tx_done_pend), 0);
    endtask

    task automatic check_reset_outputs();
        chk(rx_string == '0, "rst_rx_string", 64'(rx_string != '0), 0);
        chk(rx_length == '0, "rst_rx_length", rx_length, 0);
        chk(rx_busy == 1'b0, "rst_rx_busy", rx_busy, 0);
        chk(rx_done == 1'b0, "rst_rx_done", rx_done, 0);
        chk(rx_err == 1'b0, "rst_rx_err", rx_err, 0);
        chk(tx_busy == 1'b0, "rst_tx_busy", tx_busy, 0);
        chk(tx_done == 1'b0, "rst_tx_done", tx_done, 0);
        chk(tx_byte == 8'h00, "rst_tx_byte", tx_byte, 0);
        chk(tx_byte_req == 1'b0, "rst_tx_byte_req", tx_byte_req, 0);
    endtask

    // uart_tx stand-in: answers each byte request with a done after tx_delay clocks
    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && tx_byte_req) begin
                repeat (tx_delay) @(posedge sys_clk);
                #1 tx_byte_done = 1'b1;
                @(posedge sys_clk);
                #1 tx_byte_done = 1'b0;
                tx_done_cyc    = cyc;
                tx_req_due     = cyc;
                tx_outstanding = 1'b0;
            end
        end
    end

    // RX monitor: pop one expected event per rx_done/rx_err pulse
    always @(negedge sys_clk) begin
        if (sys_rst_n && (rx_done || rx_err)) begin
            if (rx_q.size() == 0) begin
                chk(1'b0, "rx_unexpected_pulse", {rx_done, rx_err}, 0);
            end else begin
                rx_e = rx_q.pop_front();
                chk(rx_done == !rx_e.is_err && rx_err == rx_e.is_err, "rx_kind",
                    {rx_done, rx_err}, rx_e.is_err ? 64'd1 : 64'd2);
                chk(int'(rx_length) == rx_e.len, "rx_length", rx_length, rx_e.len);
                rx_fd = -1;
                rx_ab = 8'h00;
                rx_eb = 8'h00;
                for (int i = 0; i < DATA_MAX; i++) begin
                    if (rx_fd < 0 && rx_string[8*i +: 8] !== rx_e.str[8*i +: 8]) begin
                        rx_fd = i;
                        rx_ab = rx_string[8*i +: 8];
                        rx_eb = rx_e.str[8*i +: 8];
                    end
                end
                chk(rx_fd < 0, "rx_string_first_bad_byte", rx_ab, rx_eb);
                if (rx_e.due >= 0)
                    chk(cyc >= rx_e.due - rx_e.tol && cyc <= rx_e.due + rx_e.tol,
                        "rx_event_cycle", cyc, rx_e.due);
            end
        end
    end

    // TX monitor: byte order, handshake timing and the done pulse
    always @(negedge sys_clk) begin
        if (sys_rst_n && tx_byte_req) begin
            chk(!tx_outstanding, "tx_req_overlap", 1, 0);
            tx_outstanding = 1'b1;
            chk(cyc == tx_req_due, "tx_req_cycle", cyc, tx_req_due);
            if (tx_q.size() == 0) begin
                chk(1'b0, "tx_unexpected_byte", tx_byte, 0);
            end else begin
                tx_eb = tx_q.pop_front();
                chk(tx_byte == tx_eb, "tx_byte", tx_byte, tx_eb);
            end
        end
        if (sys_rst_n && tx_done) begin
            chk(tx_done_pend > 0, "tx_done_expected", 64'(tx_done_pend), 1);
            if (tx_done_pend > 0) tx_done_pend--;
            chk(tx_q.size() == 0, "tx_all_bytes_sent", 64'(tx_q.size()), 0);
            chk(!tx_busy, "tx_busy_drops_with_done", tx_busy, 0);
            chk(cyc == tx_done_cyc, "tx_done_cycle", cyc, tx_done_cyc);
        end
    end

    initial begin
        bq_t p;

        // reset state
        #2 sys_rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();

        fork
            begin : rx_thread
                // "&&AB&&"
                p = '{8'h41, 8'h42};
                rx_frame_good(p);
                wait_rx_drain(20);
                // empty frame, then noise, then a normal frame
                p.delete();
                rx_frame_good(p);
                wait_rx_drain(20);
                rx_noise();
                rx_frame_good(rand_payload(5));
                wait_rx_drain(20);
                // overflow keeps the previous good payload
                rx_frame_overflow();
                wait_rx_drain(20);
                rx_frame_badtail(3);
                wait_rx_drain(20);
                // randomized mix, including a maximum-length payload
                rx_frame_good(rand_payload(DATA_MAX));
                wait_rx_drain(20);
                for (int f = 0; f < 20; f++) begin
                    case ($urandom_range(0, 5))
                        0: rx_frame_good(rand_payload(DATA_MAX));
                        1: rx_frame_badtail($urandom_range(1, 8));
                        2: rx_noise();
                        default: rx_frame_good(rand_payload($urandom_range(0, 40)));
                    endcase
                    wait_rx_drain(20);
                end
            end
            begin : tx_thread
                // "xyz" with a slow uart_tx and an ignored request while busy
                tx_delay = 20;
                p = rand_payload(DATA_MAX);
                p[0] = 8'h78;
                p[1] = 8'h79;
                p[2] = 8'h7A;
                tx_send(p, 3, 1'b1);
                tx_delay = 2;
                tx_send(rand_payload(DATA_MAX), 0, 1'b0);
                tx_delay = 1;
                tx_send(rand_payload(DATA_MAX), 200, 1'b0);
                for (int f = 0; f < 5; f++) begin
                    tx_delay = $urandom_range(1, 5);
                    tx_send(rand_payload(DATA_MAX), $urandom_range(0, DATA_MAX), 1'($urandom_range(0, 1)));
                end
            end
        join

        // inter-byte timeout drops a partial frame
        repeat (DELIM_CNT) rx_send(DELIM);
        rx_send(8'h41);
        rx_send(8'h42);
        rx_send(DELIM);
        push_rx_err(rx_last_cyc + TIMEOUT_CLK, 1);
        wait_rx_drain(TIMEOUT_CLK + 50);
        chk(rx_busy == 1'b0, "rx_busy_after_timeout", rx_busy, 0);
        rx_frame_good(rand_payload(4));
        wait_rx_drain(20);

        // reset in the middle of an RX frame and a TX frame
        tx_delay = 3;
        tx_start(rand_payload(DATA_MAX), 10);
        rx_send(DELIM);
        rx_send(DELIM);
        rx_send(8'h41);
        repeat (3) tick();
        #2 sys_rst_n = 1'b0;
        #1 check_reset_outputs();
        tx_q.delete();
        tx_done_pend   = 0;
        tx_outstanding = 1'b0;
        last_good      = '0;
        last_good_len  = 0;
        repeat (4) tick();
        sys_rst_n = 1'b1;
        repeat (30) tick();
        chk(!rx_busy && !tx_busy, "idle_after_reset", {rx_busy, tx_busy}, 0);
        rx_frame_good(rand_payload(6));
        wait_rx_drain(20);
        tx_delay = 2;
        tx_send(rand_payload(DATA_MAX), 4, 1'b0);

        repeat (5) tick();
        chk(rx_q.size() == 0, "rx_queue_empty_at_end", 64'(rx_q.size()), 0);
        chk(tx_q.size() == 0 && tx_done_pend == 0, "tx_queue_empty_at_end", 64'(tx_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
